// File: rtl/usb_capture_writer_if.sv
// Memory-writer bus between the capture engine and the AXI memory writer.
// The master drives a single outstanding 64-bit write; the slave acknowledges it with bmem_resp.
interface usb_capture_writer_if;
    logic        bmem_wr_en;
    logic [63:0] bmem_wr_data;
    logic [31:0] bmem_wr_addr;
    logic        bmem_resp;

    modport master (
        output bmem_wr_en,
        output bmem_wr_data,
        output bmem_wr_addr,
        input  bmem_resp
    );

    modport slave (
        input  bmem_wr_en,
        input  bmem_wr_data,
        input  bmem_wr_addr,
        output bmem_resp
    );
endinterface

// File: rtl/usb_capture_writer.sv
// Timestamping capture engine: tags USB words with a free-running counter, queues them,
// and writes each entry as two 64-bit words {flag, ts} and {data} into a wrapping ring buffer.
module usb_capture_writer #(
    parameter int          DATA_W     = 64,
    parameter int          FIFO_DEPTH = 16,
    parameter int          TS_W       = 48,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          RING_BYTES = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_i,
    input  logic                  clr_i,
    input  logic [DATA_W-1:0]     data_i,
    input  logic                  data_valid_i,
    usb_capture_writer_if.master  bmem,
    output logic [15:0]           drop_cnt_o,
    output logic                  overflow_o,
    output logic                  wrap_o,
    output logic [31:0]           entry_cnt_o
);
    localparam int          AW        = $clog2(FIFO_DEPTH);
    localparam int          EW        = TS_W + DATA_W + 1;
    localparam logic [AW:0] FULL_CNT  = (AW+1)'(FIFO_DEPTH);
    localparam logic [31:0] LAST_ADDR = BASE_ADDR + 32'(RING_BYTES) - 32'd8;

    typedef enum logic [1:0] {IDLE, WR_TS, WR_DATA} state_t;

    // Entry layout: {ts, data, drop_flag}
    logic [EW-1:0]     fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       count_q;
    logic [TS_W-1:0]   ts_q;
    logic              drop_flag_q;
    logic              clr_pend_q;
    state_t            state_q;
    logic              wr_en_q;
    logic [63:0]       wr_data_q;
    logic [31:0]       wr_addr_q;
    logic [DATA_W-1:0] hold_data_q;
    logic [15:0]       drop_cnt_q;
    logic              overflow_q;
    logic              wrap_q;
    logic [31:0]       entry_cnt_q;

    logic          push_req, push, drop, pop, ack, clearing, addr_last;
    logic [EW-1:0] rd_entry;
    logic [63:0]   word0, word1;
    logic [31:0]   next_addr;

    always_comb begin
        push_req  = en_i && data_valid_i && !clr_i;
        push      = push_req && (count_q != FULL_CNT);
        drop      = push_req && (count_q == FULL_CNT);
        ack       = (state_q != IDLE) && bmem.bmem_resp;
        clearing  = clr_i || clr_pend_q;
        // No refill while a clear is pending: the FSM must return to IDLE first.
        pop       = (count_q != '0) && !clr_i &&
                    ((state_q == IDLE) || (state_q == WR_DATA && ack && !clr_pend_q));
        rd_entry  = fifo_mem[rd_ptr_q];
        word0     = {rd_entry[0], {(63-TS_W){1'b0}}, rd_entry[EW-1 -: TS_W]};
        word1     = 64'(hold_data_q);
        addr_last = (wr_addr_q == LAST_ADDR);
        next_addr = addr_last ? BASE_ADDR : wr_addr_q + 32'd8;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {ts_q, data_i, drop_flag_q};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ts_q        <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            drop_flag_q <= 1'b0;
            clr_pend_q  <= 1'b0;
            state_q     <= IDLE;
            wr_en_q     <= 1'b0;
            wr_data_q   <= '0;
            wr_addr_q   <= BASE_ADDR;
            hold_data_q <= '0;
            drop_cnt_q  <= '0;
            overflow_q  <= 1'b0;
            wrap_q      <= 1'b0;
            entry_cnt_q <= '0;
        end else begin
            ts_q <= ts_q + TS_W'(1);

            if (clr_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
                count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop);
            end

            if (clr_i) begin
                drop_cnt_q  <= '0;
                overflow_q  <= 1'b0;
                drop_flag_q <= 1'b0;
                wrap_q      <= 1'b0;
                entry_cnt_q <= '0;
            end else if (drop) begin
                if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
                overflow_q  <= 1'b1;
                drop_flag_q <= 1'b1;
            end else if (push) begin
                drop_flag_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (clr_i) begin
                        wr_addr_q <= BASE_ADDR;
                    end else if (pop) begin
                        wr_data_q   <= word0;
                        hold_data_q <= rd_entry[DATA_W:1];
                        wr_en_q     <= 1'b1;
                        state_q     <= WR_TS;
                    end
                end
                WR_TS: begin
                    if (clr_i) clr_pend_q <= 1'b1;
                    if (ack) begin
                        wr_addr_q <= next_addr;
                        wr_data_q <= word1;
                        if (addr_last && !clearing) wrap_q <= 1'b1;
                        state_q   <= WR_DATA;
                    end
                end
                WR_DATA: begin
                    if (clr_i) clr_pend_q <= 1'b1;
                    if (ack) begin
                        if (clearing) begin
                            // In-flight entry finished at its old addresses; restart the ring.
                            clr_pend_q <= 1'b0;
                            wr_addr_q  <= BASE_ADDR;
                            wr_en_q    <= 1'b0;
                            state_q    <= IDLE;
                        end else begin
                            wr_addr_q   <= next_addr;
                            entry_cnt_q <= entry_cnt_q + 32'd1;
                            if (addr_last) wrap_q <= 1'b1;
                            if (pop) begin
                                wr_data_q   <= word0;
                                hold_data_q <= rd_entry[DATA_W:1];
                                state_q     <= WR_TS;
                            end else begin
                                wr_en_q <= 1'b0;
                                state_q <= IDLE;
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bmem.bmem_wr_en   = wr_en_q;
    assign bmem.bmem_wr_data = wr_data_q;
    assign bmem.bmem_wr_addr = wr_addr_q;
    assign drop_cnt_o        = drop_cnt_q;
    assign overflow_o        = overflow_q;
    assign wrap_o            = wrap_q;
    assign entry_cnt_o       = entry_cnt_q;
endmodule

// File: tb/tb_usb_capture_writer.sv
// Bench for usb_capture_writer: a 64-bit/depth-4/32-byte-ring instance checked by a write
// scoreboard, plus an 8-bit instance for zero-extension and enable gating.
module tb_usb_capture_writer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        en_a, clr_a, valid_a;
    logic [63:0] data_a;
    logic        en_b, clr_b, valid_b;
    logic [7:0]  data_b;
    logic [15:0] drop_a, drop_b;
    logic        ovf_a, ovf_b, wrap_a, wrap_b;
    logic [31:0] ecnt_a, ecnt_b;

    usb_capture_writer_if bus_a ();
    usb_capture_writer_if bus_b ();
    assign bus_b.bmem_resp = 1'b1;

    usb_capture_writer #(.DATA_W(64), .FIFO_DEPTH(4), .TS_W(48),
                         .BASE_ADDR(32'h0), .RING_BYTES(32)) dut_a (
        .clk(clk), .rst(rst), .en_i(en_a), .clr_i(clr_a), .data_i(data_a),
        .data_valid_i(valid_a), .bmem(bus_a), .drop_cnt_o(drop_a),
        .overflow_o(ovf_a), .wrap_o(wrap_a), .entry_cnt_o(ecnt_a));

    usb_capture_writer #(.DATA_W(8)) dut_b (
        .clk(clk), .rst(rst), .en_i(en_b), .clr_i(clr_b), .data_i(data_b),
        .data_valid_i(valid_b), .bmem(bus_b), .drop_cnt_o(drop_b),
        .overflow_o(ovf_b), .wrap_o(wrap_b), .entry_cnt_o(ecnt_b));

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    // Cycle counter matching the DUT's timestamp (0 in reset, +1 per clock).
    logic [47:0] tb_ts;
    always @(posedge clk or negedge rst) begin
        if (!rst) tb_ts <= '0;
        else      tb_ts <= tb_ts + 48'd1;
    end

    // Ack policy for dut_a: 0 = hold off, 1 = ack at once, 2 = random delay.
    int resp_mode = 0;
    always @(posedge clk) begin
        #1;
        case (resp_mode)
            1:       bus_a.bmem_resp = bus_a.bmem_wr_en;
            2:       bus_a.bmem_resp = bus_a.bmem_wr_en && ($urandom_range(0, 3) == 0);
            default: bus_a.bmem_resp = 1'b0;
        endcase
    end

    // Scoreboard for dut_a writes.
    logic [31:0] exp_addr_q [$];
    logic [63:0] exp_data_q [$];
    logic [31:0] nxt_addr;

    task automatic push_exp(input logic [47:0] ts, input logic [63:0] d, input logic flag);
        exp_addr_q.push_back(nxt_addr);
        exp_data_q.push_back({flag, 15'd0, ts});
        nxt_addr = (nxt_addr + 32'd8) % 32'd32;
        exp_addr_q.push_back(nxt_addr);
        exp_data_q.push_back(d);
        nxt_addr = (nxt_addr + 32'd8) % 32'd32;
    endtask

    logic        prev_pend = 1'b0;
    logic [31:0] prev_addr;
    logic [63:0] prev_data;
    always @(negedge clk) begin
        if (rst) begin
            if (prev_pend) begin
                check_val("hold_en",   64'(bus_a.bmem_wr_en), 64'd1);
                check_val("hold_addr", 64'(bus_a.bmem_wr_addr), 64'(prev_addr));
                check_val("hold_data", bus_a.bmem_wr_data, prev_data);
            end
            if (bus_a.bmem_wr_en && bus_a.bmem_resp) begin
                $display("a wr addr=%h data=%h", bus_a.bmem_wr_addr, bus_a.bmem_wr_data);
                if (exp_addr_q.size() == 0) begin
                    check_val("unexpected_wr", 64'(exp_addr_q.size()), 64'd1);
                end else begin
                    check_val("wr_addr", 64'(bus_a.bmem_wr_addr), 64'(exp_addr_q.pop_front()));
                    check_val("wr_data", bus_a.bmem_wr_data, exp_data_q.pop_front());
                end
            end
            prev_pend = bus_a.bmem_wr_en && !bus_a.bmem_resp;
            prev_addr = bus_a.bmem_wr_addr;
            prev_data = bus_a.bmem_wr_data;
        end
    end

    // dut_b acks every word at once; log the first two words it writes.
    int          b_wr = 0;
    logic [31:0] b_addr [2];
    logic [63:0] b_data [2];
    always @(negedge clk) begin
        if (rst && bus_b.bmem_wr_en) begin
            $display("b wr addr=%h data=%h", bus_b.bmem_wr_addr, bus_b.bmem_wr_data);
            if (b_wr < 2) begin
                b_addr[b_wr] = bus_b.bmem_wr_addr;
                b_data[b_wr] = bus_b.bmem_wr_data;
            end
            b_wr++;
        end
    end

    // Drive one valid in the current cycle (called just after a rising edge).
    task automatic drive_a(input logic [63:0] d, input bit accept, input logic flag);
        data_a  = d;
        en_a    = 1'b1;
        valid_a = 1'b1;
        if (accept) push_exp(tb_ts, d, flag);
        @(posedge clk); #1;
        valid_a = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        bit ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(posedge clk); #1;
            if (exp_addr_q.size() == 0 && !bus_a.bmem_wr_en) begin
                ok = 1'b1;
                break;
            end
        end
        check_val({tag, "_idle"}, 64'(ok), 64'd1);
    endtask

    logic [47:0] ts_b;

    initial begin
        rst = 1'b0;
        en_a = 1'b0; clr_a = 1'b0; valid_a = 1'b0; data_a = '0;
        en_b = 1'b0; clr_b = 1'b0; valid_b = 1'b0; data_b = '0;
        bus_a.bmem_resp = 1'b0;
        nxt_addr = 32'h0;
        #12;
        check_val("rst_en",   64'(bus_a.bmem_wr_en), 64'd0);
        check_val("rst_data", bus_a.bmem_wr_data, 64'd0);
        check_val("rst_addr", 64'(bus_a.bmem_wr_addr), 64'd0);
        check_val("rst_stat", {ecnt_a, drop_a, 13'd0, ovf_a, wrap_a, 1'b0}, 64'd0);
        check_val("rst_b_en", 64'(bus_b.bmem_wr_en), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;

        // Single capture at ts=5 with immediate acks, including first-write latency.
        resp_mode = 1;
        while (tb_ts != 48'd5) begin @(posedge clk); #1; end
        drive_a(64'hDEAD_BEEF_0000_0001, 1'b1, 1'b0);
        check_val("lat_n1_en", 64'(bus_a.bmem_wr_en), 64'd0);
        @(posedge clk); #1;
        check_val("lat_n2_en",   64'(bus_a.bmem_wr_en), 64'd1);
        check_val("lat_n2_data", bus_a.bmem_wr_data, 64'd5);
        wait_idle("single", 50);
        check_val("single_ecnt", 64'(ecnt_a), 64'd1);
        check_val("single_wrap", 64'(wrap_a), 64'd0);
        check_val("single_drop", 64'(drop_a), 64'd0);

        // Ring wrap: second entry fills 0x10/0x18, third lands back at 0x0/0x8.
        drive_a(64'h0000_0000_0000_0002, 1'b1, 1'b0);
        wait_idle("wrap2", 50);
        check_val("wrap_set",  64'(wrap_a), 64'd1);
        drive_a(64'h0000_0000_0000_0003, 1'b1, 1'b0);
        wait_idle("wrap3", 50);
        check_val("wrap_ecnt", 64'(ecnt_a), 64'd3);

        // Overflow: one entry held, four queued, sixth dropped.
        resp_mode = 0;
        for (int i = 0; i < 6; i++) drive_a(64'h1000 + 64'(i), (i < 5), 1'b0);
        repeat (2) @(posedge clk); #1;
        check_val("ovf_drop", 64'(drop_a), 64'd1);
        check_val("ovf_flag", 64'(ovf_a), 64'd1);
        resp_mode = 1;
        wait_idle("ovf_drain", 200);
        drive_a(64'h77, 1'b1, 1'b1);
        wait_idle("ovf_flag1", 50);
        drive_a(64'h78, 1'b1, 1'b0);
        wait_idle("ovf_flag0", 50);
        check_val("ovf_drop_hold", 64'(drop_a), 64'd1);
        check_val("ovf_ecnt",      64'(ecnt_a), 64'd10);

        // Clear while in WR_TS with a full FIFO; the push in the clear cycle is discarded.
        resp_mode = 0;
        for (int i = 0; i < 6; i++) drive_a(64'h2000 + 64'(i), (i == 0), 1'b0);
        check_val("clr_pre_en", 64'(bus_a.bmem_wr_en), 64'd1);
        clr_a = 1'b1; valid_a = 1'b1; data_a = 64'h2FFF;
        @(posedge clk); #1;
        clr_a = 1'b0; valid_a = 1'b0;
        nxt_addr = 32'h0;
        check_val("clr_drop", 64'(drop_a), 64'd0);
        check_val("clr_ovf",  64'(ovf_a), 64'd0);
        check_val("clr_wrap", 64'(wrap_a), 64'd0);
        resp_mode = 1;
        wait_idle("clr_finish", 50);
        repeat (10) @(posedge clk); #1;
        check_val("clr_quiet", 64'(bus_a.bmem_wr_en), 64'd0);
        check_val("clr_ecnt",  64'(ecnt_a), 64'd0);
        drive_a(64'h3000, 1'b1, 1'b0);
        wait_idle("clr_next", 50);
        check_val("clr_next_ecnt", 64'(ecnt_a), 64'd1);

        // Enable gating and zero-extension on the 8-bit instance.
        en_b = 1'b0; valid_b = 1'b1; data_b = 8'h11;
        repeat (3) begin @(posedge clk); #1; end
        valid_b = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        check_val("b_en0_wr",   64'(b_wr), 64'd0);
        check_val("b_en0_drop", 64'(drop_b), 64'd0);
        en_b = 1'b1; valid_b = 1'b1; data_b = 8'hA5; ts_b = tb_ts;
        @(posedge clk); #1;
        valid_b = 1'b0;
        for (int k = 0; k < 20 && b_wr < 2; k++) begin @(posedge clk); #1; end
        check_val("b_wr_cnt", 64'(b_wr), 64'd2);
        check_val("b_w0_addr", 64'(b_addr[0]), 64'd0);
        check_val("b_w0_data", b_data[0], {16'd0, ts_b});
        check_val("b_w1_addr", 64'(b_addr[1]), 64'd8);
        check_val("b_w1_data", b_data[1], 64'h0000_0000_0000_00A5);
        check_val("b_ecnt",    64'(ecnt_b), 64'd1);

        // Drop-counter saturation, then drain with random ack delays.
        resp_mode = 0;
        en_a = 1'b1; valid_a = 1'b1;
        for (int i = 0; i < 70010; i++) begin
            data_a = 64'(i);
            if (i < 5) push_exp(tb_ts, 64'(i), 1'b0);
            @(posedge clk); #1;
        end
        valid_a = 1'b0;
        check_val("sat_drop", 64'(drop_a), 64'hFFFF);
        check_val("sat_ovf",  64'(ovf_a), 64'd1);
        resp_mode = 2;
        wait_idle("sat_drain", 500);
        drive_a(64'hAB, 1'b1, 1'b1);
        wait_idle("sat_next", 100);
        check_val("sat_drop_hold", 64'(drop_a), 64'hFFFF);
        check_val("sat_ecnt",      64'(ecnt_a), 64'd7);

        // Asynchronous reset in the middle of a pending write.
        resp_mode = 0;
        drive_a(64'hCC, 1'b0, 1'b0);
        @(posedge clk); #1;
        check_val("arst_pre_en", 64'(bus_a.bmem_wr_en), 64'd1);
        #2 rst = 1'b0;
        #1;
        check_val("arst_en",   64'(bus_a.bmem_wr_en), 64'd0);
        check_val("arst_addr", 64'(bus_a.bmem_wr_addr), 64'd0);
        check_val("arst_ecnt", 64'(ecnt_a), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
